// File: rtl/watch_scan_ctrl.sv
// watch_scan_ctrl: multiplexes a packed BCD word one digit at a time onto a
// shared decoder input. Each digit gets a blanking gap and then a dwell
// window. New values are double-buffered so that a frame is never torn.
// All outputs are registered. They are computed from the next-state values,
// so each output lines up with the state register in the same cycle.

module watch_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] LOAD_DATA,
  output logic                    LOAD_ACK,
  input  logic                    LZB_EN,
  output logic [3:0]              BCD_OUT,
  output logic [NUM_DIGITS-1:0]   DIGIT_SEL,
  output logic                    FRAME_START,
  output logic                    BCD_ERR
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WORD_W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Replace every nibble above 9 with zero.
  function automatic logic [WORD_W-1:0] sanitize_bcd(input logic [WORD_W-1:0] raw);
    logic [WORD_W-1:0] clean;
    clean = raw;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (raw[4*i +: 4] > 4'd9) begin
        clean[4*i +: 4] = 4'd0;
      end else begin
        clean[4*i +: 4] = raw[4*i +: 4];
      end
    end
    return clean;
  endfunction

  // Return 1 if any nibble holds a non-BCD code.
  function automatic logic has_bad_nibble(input logic [WORD_W-1:0] raw);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bad = bad | (raw[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Select the nibble at the given digit index.
  function automatic logic [3:0] nibble_at(input logic [WORD_W-1:0] word,
                                           input logic [IDX_W-1:0]  idx);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        n = word[4*i +: 4];
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Build the mask of digits hidden by leading-zero blanking. The mask
  // covers the run of zero digits from the top down. Digit 0 is never hidden.
  function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [WORD_W-1:0] word,
                                                     input logic              lzb_on);
    logic [NUM_DIGITS-1:0] mask;
    logic                  zero_run;
    mask     = '0;
    zero_run = lzb_on;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (word[4*i +: 4] == 4'd0);
      mask[i]  = zero_run;
    end
    return mask;
  endfunction

  state_t              state_r, state_nx_s;
  logic [IDX_W-1:0]    idx_r, idx_nx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
  logic [WORD_W-1:0]   active_r, active_nx_s;
  logic [WORD_W-1:0]   shadow_r, shadow_nx_s;
  logic                pending_r, pending_nx_s;
  logic                err_r, err_nx_s;
  logic [3:0]          bcd_r, bcd_nx_s;
  logic [NUM_DIGITS-1:0] sel_r, sel_nx_s;
  logic                ack_r, ack_nx_s;
  logic                fs_r, fs_nx_s;
  logic                wrap_s;
  logic                frame_entry_s;
  logic                apply_s;

  // Next-state logic for the scan sequencer (IDLE -> BLANK -> SHOW loop).
  always_comb begin
    state_nx_s    = state_r;
    idx_nx_s      = idx_r;
    cnt_nx_s      = cnt_r;
    wrap_s        = 1'b0;
    frame_entry_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        idx_nx_s = '0;
        cnt_nx_s = '0;
        if (EN) begin
          state_nx_s    = ST_BLANK;
          frame_entry_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (!EN) begin
          state_nx_s = ST_IDLE;
          idx_nx_s   = '0;
          cnt_nx_s   = '0;
        end else if (cnt_r == CNT_W'(BLANK_CYCLES - 1)) begin
          state_nx_s = ST_SHOW;
          cnt_nx_s   = '0;
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        if (!EN) begin
          state_nx_s = ST_IDLE;
          idx_nx_s   = '0;
          cnt_nx_s   = '0;
        end else if (cnt_r == CNT_W'(DWELL_CYCLES - 1)) begin
          state_nx_s = ST_BLANK;
          cnt_nx_s   = '0;
          if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
            idx_nx_s      = '0;
            wrap_s        = 1'b1;
            frame_entry_s = 1'b1;
          end else begin
            idx_nx_s = idx_r + IDX_W'(1);
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        idx_nx_s   = '0;
        cnt_nx_s   = '0;
      end
    endcase
  end

  // Load handshake. The shadow captures the new value and the active word is
  // swapped only in IDLE or on the frame wrap. A capture in the same IDLE cycle
  // defers the apply by one cycle, so the newest data wins and only one ACK is sent.
  always_comb begin
    apply_s = pending_r & (((state_r == ST_IDLE) & ~LOAD) | wrap_s);
    if (apply_s) begin
      active_nx_s = shadow_r;
    end else begin
      active_nx_s = active_r;
    end
    if (LOAD) begin
      shadow_nx_s  = sanitize_bcd(LOAD_DATA);
      pending_nx_s = 1'b1;
    end else begin
      shadow_nx_s  = shadow_r;
      pending_nx_s = pending_r & ~apply_s;
    end
    err_nx_s = err_r | (LOAD & has_bad_nibble(LOAD_DATA));
    ack_nx_s = apply_s;
    fs_nx_s  = frame_entry_s;
  end

  // Output decode from the next state, so the registered outputs track the state register.
  always_comb begin
    sel_nx_s = '0;
    bcd_nx_s = 4'd0;
    if (state_nx_s == ST_SHOW) begin
      sel_nx_s = (NUM_DIGITS'(1) << idx_nx_s) & ~lzb_mask(active_nx_s, LZB_EN);
      bcd_nx_s = nibble_at(active_nx_s, idx_nx_s);
    end else if (state_nx_s == ST_BLANK) begin
      sel_nx_s = '0;
      bcd_nx_s = nibble_at(active_nx_s, idx_nx_s);
    end else begin
      sel_nx_s = '0;
      bcd_nx_s = 4'd0;
    end
  end

  // State, data and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      cnt_r     <= '0;
      active_r  <= '0;
      shadow_r  <= '0;
      pending_r <= 1'b0;
      err_r     <= 1'b0;
      bcd_r     <= 4'd0;
      sel_r     <= '0;
      ack_r     <= 1'b0;
      fs_r      <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      idx_r     <= idx_nx_s;
      cnt_r     <= cnt_nx_s;
      active_r  <= active_nx_s;
      shadow_r  <= shadow_nx_s;
      pending_r <= pending_nx_s;
      err_r     <= err_nx_s;
      bcd_r     <= bcd_nx_s;
      sel_r     <= sel_nx_s;
      ack_r     <= ack_nx_s;
      fs_r      <= fs_nx_s;
    end
  end

  assign LOAD_ACK    = ack_r;
  assign BCD_OUT     = bcd_r;
  assign DIGIT_SEL   = sel_r;
  assign FRAME_START = fs_r;
  assign BCD_ERR     = err_r;

endmodule

// File: tb/tb_watch_scan_ctrl.sv
// Directed testbench for watch_scan_ctrl with 4 digits, dwell 4 and blank 2.
// Inputs change 1 time unit after each rising edge. Outputs are checked at
// the same point.

module tb_watch_scan_ctrl;

  localparam int ND    = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = DWELL + BLANK;
  localparam int FRAME = ND * SLOT;

  logic          CLK;
  logic          RST_N;
  logic          EN;
  logic          LOAD;
  logic [15:0]   LOAD_DATA;
  logic          LOAD_ACK;
  logic          LZB_EN;
  logic [3:0]    BCD_OUT;
  logic [3:0]    DIGIT_SEL;
  logic          FRAME_START;
  logic          BCD_ERR;

  int tests_run;
  int tests_failed;

  watch_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK),
    .CNT_W       (16)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .LOAD       (LOAD),
    .LOAD_DATA  (LOAD_DATA),
    .LOAD_ACK   (LOAD_ACK),
    .LZB_EN     (LZB_EN),
    .BCD_OUT    (BCD_OUT),
    .DIGIT_SEL  (DIGIT_SEL),
    .FRAME_START(FRAME_START),
    .BCD_ERR    (BCD_ERR)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Checks one whole frame. On entry the sample point is t=0, which is the
  // first BLANK cycle of digit 0. The task optionally drives LZB_EN at t=0
  // and a single LOAD pulse at t=load_at. It returns at t=0 of the next frame.
  task automatic check_frame(input logic [15:0] word, input logic [3:0] strobe,
                             input logic ack0, input logic lzb,
                             input int load_at, input logic [15:0] load_val);
    int d;
    int p;
    logic [3:0] exp_sel;
    logic [3:0] exp_bcd;
    for (int t = 0; t < FRAME; t++) begin
      d = t / SLOT;
      p = t % SLOT;
      exp_sel = (p >= BLANK && strobe[d]) ? (4'b0001 << d) : 4'b0000;
      exp_bcd = word[4*d +: 4];
      chk($sformatf("sel w%04h t%0d", word, t), 32'(DIGIT_SEL), 32'(exp_sel));
      chk($sformatf("bcd w%04h t%0d", word, t), 32'(BCD_OUT), 32'(exp_bcd));
      chk($sformatf("fs w%04h t%0d", word, t), 32'(FRAME_START), 32'(t == 0));
      chk($sformatf("ack w%04h t%0d", word, t), 32'(LOAD_ACK), 32'((t == 0) && ack0));
      if (t == 0) begin
        LZB_EN = lzb;
      end
      if (t == load_at) begin
        LOAD      = 1'b1;
        LOAD_DATA = load_val;
      end else begin
        LOAD = 1'b0;
      end
      cyc();
    end
    LOAD = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RST_N     = 1'b0;
    EN        = 1'b0;
    LOAD      = 1'b1;
    LOAD_DATA = 16'hFFFF;
    LZB_EN    = 1'b0;

    // Reset holds every output at zero, even with LOAD asserted.
    cyc();
    cyc();
    chk("rst sel", 32'(DIGIT_SEL), 32'd0);
    chk("rst bcd", 32'(BCD_OUT), 32'd0);
    chk("rst ack", 32'(LOAD_ACK), 32'd0);
    chk("rst fs", 32'(FRAME_START), 32'd0);
    chk("rst err", 32'(BCD_ERR), 32'd0);
    LOAD = 1'b0;
    RST_N = 1'b1;
    cyc();

    // A load in IDLE gives an ACK two cycles after the LOAD cycle.
    LOAD = 1'b1;
    LOAD_DATA = 16'h1234;
    cyc();
    LOAD = 1'b0;
    chk("idle ack early", 32'(LOAD_ACK), 32'd0);
    cyc();
    chk("idle ack", 32'(LOAD_ACK), 32'd1);
    cyc();
    chk("idle ack clear", 32'(LOAD_ACK), 32'd0);

    // Start scanning and check the first frame. The second frame checks the
    // FRAME_START repeat and takes a load during the digit-1 SHOW window.
    EN = 1'b1;
    cyc();
    check_frame(16'h1234, 4'b1111, 1'b0, 1'b0, -1, 16'h0000);
    check_frame(16'h1234, 4'b1111, 1'b0, 1'b0, 8, 16'h5678);
    check_frame(16'h5678, 4'b1111, 1'b1, 1'b0, 8, 16'h0007);

    // Leading-zero blanking cases.
    check_frame(16'h0007, 4'b0001, 1'b1, 1'b1, 3, 16'h0000);
    check_frame(16'h0000, 4'b0001, 1'b1, 1'b1, 3, 16'h0107);
    chk("err before bad", 32'(BCD_ERR), 32'd0);
    check_frame(16'h0107, 4'b0111, 1'b1, 1'b1, 3, 16'h12A4);

    // A non-BCD nibble is stored as zero. BCD_ERR stays set through valid loads.
    chk("err set", 32'(BCD_ERR), 32'd1);
    check_frame(16'h1204, 4'b1111, 1'b1, 1'b0, 3, 16'h4321);
    chk("err sticky", 32'(BCD_ERR), 32'd1);
    check_frame(16'h4321, 4'b1111, 1'b1, 1'b0, -1, 16'h0000);

    // Drop EN during the digit-2 SHOW window, then restart.
    repeat (2 * SLOT + BLANK) cyc();
    chk("d2 show sel", 32'(DIGIT_SEL), 32'h4);
    chk("d2 show bcd", 32'(BCD_OUT), 32'h3);
    EN = 1'b0;
    cyc();
    chk("en off sel", 32'(DIGIT_SEL), 32'd0);
    chk("en off fs", 32'(FRAME_START), 32'd0);
    cyc();
    chk("idle sel", 32'(DIGIT_SEL), 32'd0);
    EN = 1'b1;
    cyc();
    check_frame(16'h4321, 4'b1111, 1'b0, 1'b0, -1, 16'h0000);

    // A reset in mid-scan drops the pending load, so no ACK ever follows.
    LOAD = 1'b1;
    LOAD_DATA = 16'h9999;
    cyc();
    LOAD = 1'b0;
    RST_N = 1'b0;
    EN = 1'b0;
    cyc();
    chk("rst2 sel", 32'(DIGIT_SEL), 32'd0);
    chk("rst2 err", 32'(BCD_ERR), 32'd0);
    chk("rst2 fs", 32'(FRAME_START), 32'd0);
    RST_N = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      chk($sformatf("no ack %0d", i), 32'(LOAD_ACK), 32'd0);
    end

    // Back-to-back loads in IDLE: the second value wins and one ACK is produced.
    LOAD = 1'b1;
    LOAD_DATA = 16'h1111;
    cyc();
    LOAD_DATA = 16'h2222;
    cyc();
    LOAD = 1'b0;
    chk("b2b ack early", 32'(LOAD_ACK), 32'd0);
    cyc();
    chk("b2b ack", 32'(LOAD_ACK), 32'd1);
    cyc();
    chk("b2b ack once", 32'(LOAD_ACK), 32'd0);
    EN = 1'b1;
    cyc();
    check_frame(16'h2222, 4'b1111, 1'b0, 1'b0, -1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
